// File: rtl/bus_arbiter3_pkg.sv
// Shared encodings for the three-master bus arbiter: FSM states, grant indices
// and the modulo-3 index increment used by arbitration and the round-robin pointer.
package bus_arbiter3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_M0 = 2'b00;
    localparam sel_t SEL_M1 = 2'b01;
    localparam sel_t SEL_M2 = 2'b10;

    function automatic sel_t next_idx3(input sel_t idx);
        return (idx == SEL_M2) ? SEL_M0 : sel_t'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/bus_arbiter3_if.sv
// Bundle of master-side request/response and slave-side bus signals.
// The arbiter uses the master modport; the environment uses the slave modport.
interface bus_arbiter3_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [2:0]              m_valid;
    logic [2:0]              m_ready;
    logic [3*ADDR_WIDTH-1:0] m_addr;
    logic [3*DATA_WIDTH-1:0] m_wdata;
    logic [2:0]              m_wen;
    logic [2:0]              m_rvalid;
    logic [DATA_WIDTH-1:0]   m_rdata;
    logic                    s_valid;
    logic                    s_ready;
    logic [ADDR_WIDTH-1:0]   s_addr;
    logic [DATA_WIDTH-1:0]   s_wdata;
    logic                    s_wen;
    logic                    s_rvalid;
    logic [DATA_WIDTH-1:0]   s_rdata;
    logic [1:0]              sel;

    modport master (
        input  m_valid, m_addr, m_wdata, m_wen, s_ready, s_rvalid, s_rdata,
        output m_ready, m_rvalid, m_rdata, s_valid, s_addr, s_wdata, s_wen, sel
    );

    modport slave (
        output m_valid, m_addr, m_wdata, m_wen, s_ready, s_rvalid, s_rdata,
        input  m_ready, m_rvalid, m_rdata, s_valid, s_addr, s_wdata, s_wen, sel
    );
endinterface

// File: rtl/arb_pick3.sv
// Combinational winner selection among three requesters, searching from
// ptr_i upward modulo 3. A constant zero pointer yields fixed priority 0 > 1 > 2.
module arb_pick3
    import bus_arbiter3_pkg::*;
(
    input  logic [2:0] valid_i,
    input  sel_t       ptr_i,
    output sel_t       idx_o
);
    sel_t cand0;
    sel_t cand1;
    sel_t cand2;

    assign cand0 = ptr_i;
    assign cand1 = next_idx3(cand0);
    assign cand2 = next_idx3(cand1);

    always_comb begin
        idx_o = SEL_M0;
        if (valid_i[cand0]) begin
            idx_o = cand0;
        end else if (valid_i[cand1]) begin
            idx_o = cand1;
        end else if (valid_i[cand2]) begin
            idx_o = cand2;
        end
    end
endmodule

// File: rtl/mux3_keyed.sv
// Multi-bit 3:1 mux keyed by a 2-bit index; the unused key 2'b11 yields zero.
module mux3_keyed
    import bus_arbiter3_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    input  sel_t         key_i,
    output logic [W-1:0] q_o
);
    always_comb begin
        q_o = '0;
        unique case (key_i)
            SEL_M0:  q_o = d0_i;
            SEL_M1:  q_o = d1_i;
            SEL_M2:  q_o = d2_i;
            default: q_o = '0;
        endcase
    end
endmodule

// File: rtl/bus_arbiter3.sv
// Three-master to one-slave arbiter with a single outstanding transaction.
// Define BUS_ARBITER3_RR_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module bus_arbiter3
    import bus_arbiter3_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    bus_arbiter3_if.master  bif
);
    localparam int PW = ADDR_WIDTH + DATA_WIDTH + 1;

    state_e state_q;
    state_e state_d;
    sel_t   sel_q;
    sel_t   sel_d;
    sel_t   rr_ptr;
    sel_t   pick_idx;
    logic   req_active;

    logic [PW-1:0] pay [3];
    logic [PW-1:0] pay_sel;

`ifdef BUS_ARBITER3_RR_EN
    sel_t ptr_q;
    sel_t ptr_d;

    // Pointer moves past the master just served, once its response is delivered.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_RESP && bif.s_rvalid) begin
            ptr_d = next_idx3(sel_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= SEL_M0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign rr_ptr = ptr_q;
`else
    assign rr_ptr = SEL_M0;
`endif

    arb_pick3 u_pick (
        .valid_i (bif.m_valid),
        .ptr_i   (rr_ptr),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_M0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        req_active = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|bif.m_valid) begin
                    sel_d   = pick_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                req_active = 1'b1;
                if (bif.s_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bif.s_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshakes only ever reach the granted master.
    for (genvar gi = 0; gi < 3; gi++) begin : g_master
        assign pay[gi] = {bif.m_wen[gi],
                          bif.m_wdata[gi*DATA_WIDTH +: DATA_WIDTH],
                          bif.m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]};
        assign bif.m_ready[gi]  = req_active && (sel_q == 2'(gi)) && bif.s_ready;
        assign bif.m_rvalid[gi] = (state_q == ST_RESP) && (sel_q == 2'(gi)) && bif.s_rvalid;
    end

    mux3_keyed #(.W(PW)) u_pay_mux (
        .d0_i  (pay[0]),
        .d1_i  (pay[1]),
        .d2_i  (pay[2]),
        .key_i (sel_q),
        .q_o   (pay_sel)
    );

    assign {bif.s_wen, bif.s_wdata, bif.s_addr} = pay_sel;
    assign bif.s_valid = req_active;
    assign bif.m_rdata = bif.s_rdata;
    assign bif.sel     = sel_q;
endmodule

// File: tb/tb_bus_arbiter3.sv
// Directed bench for bus_arbiter3: per-cycle vector table plus hand-written
// sequences for continuous contention and reset during a response phase.
module tb_bus_arbiter3;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_arbiter3_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

    bus_arbiter3 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    typedef struct {
        logic [2:0]  mv;
        logic        sr;
        logic        srv;
        logic [31:0] rdata;
        logic        exp_sv;
        logic [2:0]  exp_mr;
        logic [2:0]  exp_mrv;
        logic [1:0]  exp_sel;
    } vec_t;

    vec_t        vecs [17];
    logic [31:0] addr_c  [3];
    logic [31:0] wdata_c [3];
    logic [2:0]  wen_c;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_payload(input string name, input logic [1:0] s);
        check({name, "_addr"}, 64'(bif.s_addr), 64'(addr_c[s]));
        check({name, "_wdata"}, 64'(bif.s_wdata), 64'(wdata_c[s]));
        check({name, "_wen"}, 64'(bif.s_wen), 64'(wen_c[s]));
    endtask

    function automatic logic [2:0] onehot(input logic [1:0] s);
        logic [2:0] r;
        r = 3'b000;
        r[s] = 1'b1;
        return r;
    endfunction

    initial begin
        logic [1:0] exp_g;
        int         last_grant;
        bit         found;

        for (int i = 0; i < 3; i++) begin
            addr_c[i]  = 32'h1000_0000 + 32'(i) * 32'h44;
            wdata_c[i] = 32'hD000_0000 + 32'(i);
        end
        wen_c = 3'b101;

        //           mv      sr    srv   rdata          sv    mr      mrv     sel
        vecs[0]  = '{3'b010, 1'b1, 1'b0, 32'h0,         1'b0, 3'b000, 3'b000, 2'b00};
        vecs[1]  = '{3'b010, 1'b1, 1'b0, 32'h0,         1'b1, 3'b010, 3'b000, 2'b01};
        vecs[2]  = '{3'b000, 1'b1, 1'b0, 32'h0,         1'b0, 3'b000, 3'b000, 2'b01};
        vecs[3]  = '{3'b000, 1'b1, 1'b1, 32'hDEADBEEF,  1'b0, 3'b000, 3'b010, 2'b01};
        vecs[4]  = '{3'b000, 1'b0, 1'b0, 32'h0,         1'b0, 3'b000, 3'b000, 2'b01};
        vecs[5]  = '{3'b001, 1'b0, 1'b0, 32'h0,         1'b0, 3'b000, 3'b000, 2'b01};
        vecs[6]  = '{3'b001, 1'b0, 1'b0, 32'h0,         1'b1, 3'b000, 3'b000, 2'b00};
        vecs[7]  = '{3'b101, 1'b0, 1'b1, 32'h12345678,  1'b1, 3'b000, 3'b000, 2'b00};
        vecs[8]  = '{3'b101, 1'b0, 1'b0, 32'h0,         1'b1, 3'b000, 3'b000, 2'b00};
        vecs[9]  = '{3'b101, 1'b0, 1'b0, 32'h0,         1'b1, 3'b000, 3'b000, 2'b00};
        vecs[10] = '{3'b101, 1'b1, 1'b0, 32'h0,         1'b1, 3'b001, 3'b000, 2'b00};
        vecs[11] = '{3'b100, 1'b1, 1'b0, 32'h0,         1'b0, 3'b000, 3'b000, 2'b00};
        vecs[12] = '{3'b100, 1'b1, 1'b1, 32'hCAFEF00D,  1'b0, 3'b000, 3'b001, 2'b00};
        vecs[13] = '{3'b100, 1'b1, 1'b0, 32'h0,         1'b0, 3'b000, 3'b000, 2'b00};
        vecs[14] = '{3'b100, 1'b1, 1'b0, 32'h0,         1'b1, 3'b100, 3'b000, 2'b10};
        vecs[15] = '{3'b000, 1'b1, 1'b1, 32'hA5A5A5A5,  1'b0, 3'b000, 3'b100, 2'b10};
        vecs[16] = '{3'b000, 1'b1, 1'b0, 32'h0,         1'b0, 3'b000, 3'b000, 2'b10};

        bif.m_valid  = 3'b000;
        bif.m_addr   = {addr_c[2], addr_c[1], addr_c[0]};
        bif.m_wdata  = {wdata_c[2], wdata_c[1], wdata_c[0]};
        bif.m_wen    = wen_c;
        bif.s_ready  = 1'b0;
        bif.s_rvalid = 1'b0;
        bif.s_rdata  = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_valid", 64'(bif.s_valid), 64'(0));
        check("rst_m_ready", 64'(bif.m_ready), 64'(0));
        check("rst_m_rvalid", 64'(bif.m_rvalid), 64'(0));
        check("rst_sel", 64'(bif.sel), 64'(0));
        rst = 1'b0;

        // Per-cycle vector table
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            bif.m_valid  = vecs[i].mv;
            bif.s_ready  = vecs[i].sr;
            bif.s_rvalid = vecs[i].srv;
            bif.s_rdata  = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("v%0d_s_valid", i), 64'(bif.s_valid), 64'(vecs[i].exp_sv));
            check($sformatf("v%0d_m_ready", i), 64'(bif.m_ready), 64'(vecs[i].exp_mr));
            check($sformatf("v%0d_m_rvalid", i), 64'(bif.m_rvalid), 64'(vecs[i].exp_mrv));
            check($sformatf("v%0d_sel", i), 64'(bif.sel), 64'(vecs[i].exp_sel));
            check($sformatf("v%0d_m_rdata", i), 64'(bif.m_rdata), 64'(vecs[i].rdata));
            if (vecs[i].exp_sv) check_payload($sformatf("v%0d", i), vecs[i].exp_sel);
            $display("vec %0d: mv=%b s_valid=%b m_ready=%b m_rvalid=%b sel=%0d",
                     i, vecs[i].mv, bif.s_valid, bif.m_ready, bif.m_rvalid, bif.sel);
        end

        // Continuous contention: all masters valid, slave always ready and responding
        bif.m_valid  = 3'b111;
        bif.s_ready  = 1'b1;
        bif.s_rvalid = 1'b1;
        bif.s_rdata  = 32'h0BAD_F00D;
        last_grant   = 0;
        for (int t = 0; t < 6; t++) begin
`ifdef BUS_ARBITER3_RR_EN
            exp_g = 2'(t % 3);
`else
            exp_g = 2'b00;
`endif
            found = 1'b0;
            for (int w = 0; w < 12 && !found; w++) begin
                @(negedge clk);
                if (bif.s_valid) found = 1'b1;
            end
            check($sformatf("contend%0d_found", t), 64'(found), 64'(1));
            check($sformatf("contend%0d_sel", t), 64'(bif.sel), 64'(exp_g));
            check($sformatf("contend%0d_m_ready", t), 64'(bif.m_ready), 64'(onehot(exp_g)));
            check_payload($sformatf("contend%0d", t), exp_g);
            if (t > 0) check($sformatf("contend%0d_spacing", t), 64'(cyc - last_grant), 64'(3));
            last_grant = cyc;
            @(negedge clk);
            check($sformatf("contend%0d_m_rvalid", t), 64'(bif.m_rvalid), 64'(onehot(exp_g)));
            check($sformatf("contend%0d_m_rdata", t), 64'(bif.m_rdata), 64'(32'h0BAD_F00D));
            $display("contend %0d: granted master %0d at cycle %0d", t, bif.sel, cyc);
        end
        @(posedge clk);
        #1;
        bif.m_valid  = 3'b000;
        bif.s_rvalid = 1'b0;

        // Reset during the response phase of a master-1 transaction
        @(posedge clk);
        #1;
        bif.m_valid = 3'b010;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstseq_req_s_valid", 64'(bif.s_valid), 64'(1));
        check("rstseq_req_sel", 64'(bif.sel), 64'(2'b01));
        @(posedge clk);
        #1;
        bif.m_valid = 3'b000;
        @(negedge clk);
        check("rstseq_resp_s_valid", 64'(bif.s_valid), 64'(0));
        check("rstseq_resp_sel", 64'(bif.sel), 64'(2'b01));
        rst = 1'b1;
        @(posedge clk);
        #1;
        bif.s_rvalid = 1'b1;
        bif.s_rdata  = 32'h7777_7777;
        @(negedge clk);
        check("rstseq_after_s_valid", 64'(bif.s_valid), 64'(0));
        check("rstseq_after_m_rvalid", 64'(bif.m_rvalid), 64'(0));
        check("rstseq_after_m_ready", 64'(bif.m_ready), 64'(0));
        check("rstseq_after_sel", 64'(bif.sel), 64'(0));
        $display("reset seq: s_valid=%b m_rvalid=%b sel=%0d", bif.s_valid, bif.m_rvalid, bif.sel);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bif.s_rvalid = 1'b0;
        bif.m_valid  = 3'b100;
        found = 1'b0;
        for (int w = 0; w < 8 && !found; w++) begin
            @(negedge clk);
            if (bif.s_valid) found = 1'b1;
        end
        check("rstseq_m2_found", 64'(found), 64'(1));
        check("rstseq_m2_sel", 64'(bif.sel), 64'(2'b10));
        check("rstseq_m2_m_ready", 64'(bif.m_ready), 64'(3'b100));
        check_payload("rstseq_m2", 2'b10);
        @(posedge clk);
        #1;
        bif.m_valid  = 3'b000;
        bif.s_rvalid = 1'b1;
        bif.s_rdata  = 32'h2222_0002;
        @(negedge clk);
        check("rstseq_m2_m_rvalid", 64'(bif.m_rvalid), 64'(3'b100));
        check("rstseq_m2_m_rdata", 64'(bif.m_rdata), 64'(32'h2222_0002));
        $display("reset seq: master 2 served, m_rvalid=%b", bif.m_rvalid);
        @(posedge clk);
        #1;
        bif.s_rvalid = 1'b0;
        @(negedge clk);
        check("final_idle_s_valid", 64'(bif.s_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bus_arbiter3.md
BUS_ARBITER3 -- requirements
Module: bus_arbiter3

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the write and read data.
REQ-002 Parameter ADDR_WIDTH, default 32: width of the address.
REQ-003 The block SHALL have these ports; one clock; reset is synchronous and active-high:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- m_valid  in  3  request valid, one bit per master (bit i = master i).
- m_ready  out  3  request accepted, one bit per master.
- m_addr  in  3*ADDR_WIDTH  packed addresses; master i at [i*AW +: AW].
- m_wdata  in  3*DATA_WIDTH  packed write data; master i at [i*DW +: DW].
- m_wen  in  3  write enable, one bit per master.
- m_rvalid  out  3  response valid, one bit per master.
- m_rdata  out  DATA_WIDTH  response data, broadcast to all masters.
- s_valid  out  1  slave request valid.
- s_ready  in  1  slave request accepted.
- s_addr  out  ADDR_WIDTH  address of the granted master.
- s_wdata  out  DATA_WIDTH  write data of the granted master.
- s_wen  out  1  write enable of the granted master.
- s_rvalid  in  1  slave response valid.
- s_rdata  in  DATA_WIDTH  slave response data.
- sel  out  2  granted master index: 00, 01 or 10; 11 is never driven.

Function
REQ-004 The FSM SHALL have three states, IDLE, REQ and RESP, with at most one transaction outstanding.
REQ-005 IDLE: if any m_valid bit is set, the block SHALL register the winner into sel and move to REQ on the next edge; otherwise it SHALL stay in IDLE.
REQ-006 REQ: s_valid=1; s_addr, s_wdata and s_wen come from master sel; m_ready[sel]=s_ready; all other m_ready bits are 0.
REQ-007 REQ: on s_valid&&s_ready the FSM SHALL move to RESP.
REQ-008 REQ: s_rvalid is ignored; the slave SHALL respond no earlier than the cycle after acceptance.
REQ-009 RESP: s_valid=0; m_rvalid[sel]=s_rvalid, combinationally; m_rdata=s_rdata in all states.
REQ-010 RESP: on s_rvalid the FSM SHALL return to IDLE.
REQ-011 The minimum request-to-s_valid latency SHALL be 1 cycle.
REQ-012 The minimum back-to-back grant spacing SHALL be 3 cycles (IDLE -> REQ -> RESP -> IDLE).
REQ-013 sel SHALL be stable from the cycle it is registered until the FSM returns to IDLE.
REQ-014 A master SHALL hold m_valid and its payload until m_ready; dropping m_valid in REQ is a protocol violation and the block is not required to detect it.
REQ-015 A m_valid change for a non-granted master SHALL NOT affect the current transaction.
REQ-016 m_ready and m_rvalid SHALL never be asserted for a non-granted master.
REQ-017 Outside REQ all m_ready bits SHALL be 0; outside RESP all m_rvalid bits SHALL be 0.

Reset
REQ-018 While rst=1: FSM=IDLE, sel=2'b00, round-robin pointer=0, s_valid=0, m_ready=0, m_rvalid=0.
REQ-019 rst asserted in REQ or RESP SHALL abandon the transaction with no response delivered; the slave SHALL be reset by the same rst.

Configuration
REQ-020 With macro BUS_ARBITER3_RR_EN defined, arbitration SHALL be round-robin.
- A 2-bit pointer p holds the highest-priority index.
- Search order is p, p+1, p+2, modulo 3.
- On return to IDLE, p SHALL become (sel+1) mod 3; p=2 wraps to 0.
REQ-021 Without BUS_ARBITER3_RR_EN, arbitration SHALL be fixed priority 0 > 1 > 2 and no pointer register SHALL exist.

Structure
REQ-022 State encodings (IDLE=0, REQ=1, RESP=2) and sel encodings SHALL live in a shared header/package, bus_arbiter3_pkg.
REQ-023 The winner selection SHALL be a combinational sub-module, arb_pick3 (inputs: valid[2:0] and pointer; output: 2-bit index).
REQ-024 Payload steering SHALL use the team's existing 3:1 multi-bit keyed mux with sel as the key.

Verification
REQ-025 Single request: m_valid=3'b010, s_ready=1, s_rvalid 2 cycles later with rdata=0xDEADBEEF -> sel=01, s_valid one cycle after the request, m_rvalid=3'b010 with m_rdata=0xDEADBEEF, back to IDLE.
REQ-026 All three masters continuously valid under RR_EN -> grant order 0,1,2,0,1,2.
REQ-027 Same stimulus without RR_EN -> master 0 granted every time.
REQ-028 Slave backpressure: s_ready low 4 cycles -> s_valid held and s_addr stable for 4 cycles, m_ready low until cycle 5.
REQ-029 Reset mid-operation: rst=1 in RESP -> next cycle s_valid=0, m_rvalid=0, sel=00; a later request from master 2 under RR_EN is granted first.
REQ-030 Stray response: s_rvalid=1 during REQ -> no m_rvalid bit asserted and the FSM stays in REQ.
